matmul_ctrl: RTL and testbench

Sequencer and multiply-accumulate engine for the matrix-multiply datapath. It sits between the x/y operand BRAMs and the z result BRAM inside `matmul_top`. After a `start` pulse it computes z = x·y for N×N row-major matrices by issuing operand read addresses, accumulating products and writing each result element. It then raises `done` for the host or bench.

---
 rtl/matmul_pkg.sv | 17 +
 rtl/matmul_ctrl_if.sv | 28 ++
 rtl/matmul_mac.sv | 39 +++
 rtl/matmul_ctrl.sv | 143 ++++++++++++++
 tb/tb_matmul_ctrl.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared types and default sizing for the matrix-multiply controller.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    WRITE,
    DONE
  } matmul_state_t;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_N          = 8;
  localparam int ELEM_CYCLES    = DEF_N + 2;

endpackage

// File: rtl/matmul_ctrl_if.sv
// Handshake and BRAM-port bundle between matmul_ctrl (master) and the host/BRAM side (slave).
interface matmul_ctrl_if import matmul_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic                  start;
  logic                  done;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] x_rd_addr;
  logic [DATA_WIDTH-1:0] x_dout;
  logic [ADDR_WIDTH-1:0] y_rd_addr;
  logic [DATA_WIDTH-1:0] y_dout;
  logic [ADDR_WIDTH-1:0] z_wr_addr;
  logic                  z_wr_en;
  logic [DATA_WIDTH-1:0] z_din;

  modport master (
    input  start, x_dout, y_dout,
    output done, busy, x_rd_addr, y_rd_addr, z_wr_addr, z_wr_en, z_din
  );

  modport slave (
    output start, x_dout, y_dout,
    input  done, busy, x_rd_addr, y_rd_addr, z_wr_addr, z_wr_en, z_din
  );

endinterface

// File: rtl/matmul_mac.sv
// Registered multiply-accumulate; product and sum both wrap to DATA_WIDTH bits.
module matmul_mac import matmul_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] acc_o
);

  logic [DATA_WIDTH-1:0] acc_q;
  logic [DATA_WIDTH-1:0] acc_d;
  logic [DATA_WIDTH-1:0] product;

  // Clear wins over accumulate so a new element never inherits a stale product.
  always_comb begin
    product = a_i * b_i;
    acc_d   = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + product;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/matmul_ctrl.sv
// FSM, i/j/k counters and address generation for z = x*y (N x N, row-major).
// Optional MATMUL_CTRL_PERF_EN adds a 32-bit busy-cycle counter output.
module matmul_ctrl import matmul_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int N          = DEF_N
) (
  input  logic         clock,
  input  logic         reset,
  matmul_ctrl_if.master bus
`ifdef MATMUL_CTRL_PERF_EN
  ,
  output logic [31:0]  cycle_count
`endif
);

  localparam int              IDX_W   = $clog2(N);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

  matmul_state_t state_q, state_d;
  logic [IDX_W-1:0] rowIdx_q, rowIdx_d;
  logic [IDX_W-1:0] colIdx_q, colIdx_d;
  logic [IDX_W-1:0] kIdx_q, kIdx_d;
  logic accValid_q;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic zWrEn_q, zWrEn_d;
  logic accept;
  logic macClr;
  logic [DATA_WIDTH-1:0] acc;

  assign accept = ((state_q == IDLE) || (state_q == DONE)) && bus.start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = FETCH;
      FETCH:      if (kIdx_q == IDX_MAX) state_d = WAIT;
      WAIT:       state_d = WRITE;
      WRITE: begin
        if ((rowIdx_q == IDX_MAX) && (colIdx_q == IDX_MAX)) state_d = DONE;
        else                                                 state_d = FETCH;
      end
      default:    state_d = IDLE;
    endcase
  end

  // Decoding from state_d makes the status strobes true registers aligned with the state.
  always_comb begin
    busy_d  = (state_d == FETCH) || (state_d == WAIT) || (state_d == WRITE);
    done_d  = (state_d == DONE);
    zWrEn_d = (state_d == WRITE);
  end

  always_comb begin
    rowIdx_d = rowIdx_q;
    colIdx_d = colIdx_q;
    kIdx_d   = kIdx_q;
    if (accept) begin
      rowIdx_d = '0;
      colIdx_d = '0;
      kIdx_d   = '0;
    end else if (state_q == FETCH) begin
      kIdx_d = kIdx_q + 1'b1;
    end else if (state_q == WRITE) begin
      kIdx_d = '0;
      if (colIdx_q != IDX_MAX) begin
        colIdx_d = colIdx_q + 1'b1;
      end else if (rowIdx_q != IDX_MAX) begin
        colIdx_d = '0;
        rowIdx_d = rowIdx_q + 1'b1;
      end
    end
  end

  // accValid_q marks the cycle in which BRAM data for a FETCH address is on x_dout/y_dout.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rowIdx_q   <= '0;
      colIdx_q   <= '0;
      kIdx_q     <= '0;
      accValid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zWrEn_q    <= 1'b0;
    end else begin
      rowIdx_q   <= rowIdx_d;
      colIdx_q   <= colIdx_d;
      kIdx_q     <= kIdx_d;
      accValid_q <= (state_q == FETCH);
      busy_q     <= busy_d;
      done_q     <= done_d;
      zWrEn_q    <= zWrEn_d;
    end
  end

  assign macClr = accept || (state_q == WRITE);

  matmul_mac #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clr_i (macClr),
    .en_i  (accValid_q),
    .a_i   (bus.x_dout),
    .b_i   (bus.y_dout),
    .acc_o (acc)
  );

  assign bus.x_rd_addr = ADDR_WIDTH'({rowIdx_q, kIdx_q});
  assign bus.y_rd_addr = ADDR_WIDTH'({kIdx_q, colIdx_q});
  assign bus.z_wr_addr = ADDR_WIDTH'({rowIdx_q, colIdx_q});
  assign bus.z_din     = acc;
  assign bus.z_wr_en   = zWrEn_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef MATMUL_CTRL_PERF_EN
  logic [31:0] cycleCount_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cycleCount_q <= '0;
    end else if (accept) begin
      cycleCount_q <= '0;
    end else if (busy_q) begin
      cycleCount_q <= cycleCount_q + 32'd1;
    end
  end

  assign cycle_count = cycleCount_q;
`endif

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl with behavioural x/y/z BRAMs (1-cycle read latency).
module tb_matmul_ctrl;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int N  = 8;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  matmul_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

`ifdef MATMUL_CTRL_PERF_EN
  logic [31:0] cycleCount;
`endif

  matmul_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .N(N)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
`ifdef MATMUL_CTRL_PERF_EN
    ,
    .cycle_count(cycleCount)
`endif
  );

  logic [DW-1:0] xMem [1024];
  logic [DW-1:0] yMem [1024];
  logic [DW-1:0] zMem [1024];
  logic [DW-1:0] xDoutR = '0;
  logic [DW-1:0] yDoutR = '0;
  logic zClearReq = 1'b0;
  logic prevWrEn = 1'b0;
  int   writeCount = 0;
  int   doubleCount = 0;

  assign bus.x_dout = xDoutR;
  assign bus.y_dout = yDoutR;

  // BRAM models plus write-strobe bookkeeping; z is refilled with a poison value on request.
  always @(posedge clock) begin
    xDoutR   <= xMem[bus.x_rd_addr];
    yDoutR   <= yMem[bus.y_rd_addr];
    prevWrEn <= bus.z_wr_en;
    if (bus.z_wr_en) begin
      writeCount <= writeCount + 1;
      if (prevWrEn) doubleCount <= doubleCount + 1;
    end
    if (zClearReq) begin
      for (int a = 0; a < 1024; a++) zMem[a] <= 32'hDEADBEEF;
    end else if (bus.z_wr_en) begin
      zMem[bus.z_wr_addr] <= bus.z_din;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Pattern 0: x=identity, y[n]=n. Pattern 1: x=2, y=3. Pattern 2: x=y=all ones.
  task automatic loadPattern(input int p);
    for (int n = 0; n < 1024; n++) begin
      xMem[n] = '0;
      yMem[n] = '0;
      if (n < N * N) begin
        case (p)
          0: begin
            xMem[n] = ((n / N) == (n % N)) ? 32'd1 : 32'd0;
            yMem[n] = 32'(n);
          end
          1: begin
            xMem[n] = 32'd2;
            yMem[n] = 32'd3;
          end
          default: begin
            xMem[n] = 32'hFFFFFFFF;
            yMem[n] = 32'hFFFFFFFF;
          end
        endcase
      end
    end
    zClearReq = 1'b1;
    @(negedge clock);
    zClearReq = 1'b0;
  endtask

  // Raises start for edge 0 and returns the first cycle in which done is seen high.
  task automatic applyStimulus(input int pulseCycle, output int doneCycle);
    bus.start = 1'b1;
    doneCycle = -1;
    for (int c = 1; c <= 1000; c++) begin
      @(negedge clock);
      bus.start = (c == pulseCycle);
      if (bus.done) begin
        doneCycle = c;
        break;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic runCheck(input string tag, input int p, input int pulseCycle);
    int doneCycle;
    int w0;
    int d0;
    logic [31:0] expZ;
    w0 = writeCount;
    d0 = doubleCount;
    applyStimulus(pulseCycle, doneCycle);
    checkOutput({tag, " doneCycle"}, 32'(doneCycle), 32'd641);
    checkOutput({tag, " busyAtDone"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " writeCount"}, 32'(writeCount - w0), 32'd64);
    checkOutput({tag, " doublePulse"}, 32'(doubleCount - d0), 32'd0);
`ifdef MATMUL_CTRL_PERF_EN
    checkOutput({tag, " cycleCount"}, cycleCount, 32'd640);
`endif
    for (int n = 0; n < N * N; n++) begin
      case (p)
        0:       expZ = 32'(n);
        1:       expZ = 32'h00000030;
        default: expZ = 32'h00000008;
      endcase
      checkOutput($sformatf("%s z[%0d]", tag, n), zMem[n], expZ);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, " z_wr_en"}, 32'(bus.z_wr_en), 32'd0);
    checkOutput({tag, " x_rd_addr"}, 32'(bus.x_rd_addr), 32'd0);
    checkOutput({tag, " y_rd_addr"}, 32'(bus.y_rd_addr), 32'd0);
    checkOutput({tag, " z_wr_addr"}, 32'(bus.z_wr_addr), 32'd0);
    checkOutput({tag, " z_din"}, bus.z_din, 32'd0);
`ifdef MATMUL_CTRL_PERF_EN
    checkOutput({tag, " cycleCount"}, cycleCount, 32'd0);
`endif
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clock);
    checkResetOutputs("por");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("idle done", 32'(bus.done), 32'd0);
    checkOutput("idle busy", 32'(bus.busy), 32'd0);

    loadPattern(0);
    runCheck("identity", 0, 0);

    // Starts while done is high, so this is also the back-to-back case.
    loadPattern(1);
    runCheck("twos_threes", 1, 0);

    loadPattern(2);
    runCheck("wrap", 2, 0);

    loadPattern(0);
    runCheck("ignored_start", 0, 100);

    // Cycle 300 is the WRITE of element 29 (i=3, j=5, k back at 0).
    loadPattern(1);
    bus.start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    checkOutput("pre_reset z_wr_en", 32'(bus.z_wr_en), 32'd1);
    checkOutput("pre_reset z_wr_addr", 32'(bus.z_wr_addr), 32'd29);
    checkOutput("pre_reset x_rd_addr", 32'(bus.x_rd_addr), 32'd24);
    checkOutput("pre_reset y_rd_addr", 32'(bus.y_rd_addr), 32'd5);
    checkOutput("pre_reset busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("post_reset busy", 32'(bus.busy), 32'd0);
    checkOutput("post_reset done", 32'(bus.done), 32'd0);

    loadPattern(1);
    runCheck("after_reset", 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
